uart_word_tx: RTL

Serializes one 64-bit word into eight back-to-back 8N1 UART frames on a single `txd` line, least-significant byte first. It is the transmit end of the UART link: it takes words from the PUF controller over a valid/ready handshake and drives the serial line to the host. The partner receive block reassembles the same eight-byte, LSB-byte-first framing into a 64-bit word.

---
 rtl/uart_word_tx.sv | 126 ++++++++++++
 1 files changed

// File: rtl/uart_word_tx.sv
// 64-bit word to eight back-to-back 8N1 UART frames, least-significant byte first.
// Single clock, asynchronous active-high reset, all outputs registered.
module uart_word_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] input_data,
    input  logic        input_valid,
    output logic        input_ready,
    output logic        txd,
    output logic        busy,
    output logic [1:0]  state_o
);

    localparam int CW = $clog2(PRESCALE);
    localparam logic [CW-1:0] RELOAD   = CW'(PRESCALE - 1);
    localparam logic [2:0]    LAST_BIT = 3'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t         state_q;
    logic [63:0]    sr_q;
    logic [CW-1:0]  baud_q;
    logic [2:0]     bit_q;
    logic [2:0]     byte_q;
    logic           txd_q;
    logic           ready_q;
    logic           busy_q;

    logic [63:0]    sr_shift_d;
    logic           baud_zero_d;
    logic [CW-1:0]  baud_dec_d;

    assign sr_shift_d  = {1'b0, sr_q[63:1]};
    assign baud_zero_d = (baud_q == '0);
    assign baud_dec_d  = baud_q - CW'(1);

    // Handshake: a word moves on a rising edge where input_valid and
    // input_ready are both high; input_ready only rises in IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sr_q    <= '0;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            txd_q   <= 1'b1;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // ready stays low until the first edge after reset release
                    if (!ready_q) begin
                        ready_q <= 1'b1;
                    end else if (input_valid) begin
                        sr_q    <= input_data;
                        byte_q  <= '0;
                        baud_q  <= RELOAD;
                        txd_q   <= 1'b0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (!baud_zero_d) begin
                        baud_q <= baud_dec_d;
                    end else begin
                        txd_q   <= sr_q[0];
                        bit_q   <= '0;
                        baud_q  <= RELOAD;
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (!baud_zero_d) begin
                        baud_q <= baud_dec_d;
                    end else begin
                        // shift on every data bit, including the last, so the
                        // next byte's bit 0 lands in sr_q[0]
                        sr_q   <= sr_shift_d;
                        baud_q <= RELOAD;
                        if (bit_q != LAST_BIT) begin
                            txd_q <= sr_shift_d[0];
                            bit_q <= bit_q + 3'd1;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= S_STOP;
                        end
                    end
                end
                S_STOP: begin
                    if (!baud_zero_d) begin
                        baud_q <= baud_dec_d;
                    end else if (byte_q != 3'd7) begin
                        byte_q  <= byte_q + 3'd1;
                        txd_q   <= 1'b0;
                        baud_q  <= RELOAD;
                        state_q <= S_START;
                    end else begin
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign input_ready = ready_q;
    assign txd         = txd_q;
    assign busy        = busy_q;
    assign state_o     = state_q;

endmodule
